// File: rtl/adder_word_sequencer_if.sv
// Handshake and adder-slice bundle for adder_word_sequencer.
// The slave modport is the sequencer's view; the master modport is the producer/consumer/adder side.
interface adder_word_sequencer_if #(
    parameter int WORDS = 4
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [16*WORDS-1:0]   in_a;
    logic [16*WORDS-1:0]   in_b;
    logic                  in_cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*WORDS-1:0]   out_sum;
    logic                  out_cout;
    logic [15:0]           add_a;
    logic [15:0]           add_b;
    logic                  add_cin;
    logic [15:0]           add_sum;
    logic                  add_cout;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
        output in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
        input  in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin
    );
endinterface

// File: rtl/adder_word_sequencer.sv
// Multi-cycle wide adder: streams WORDS 16-bit slices LSB first through an
// external 16-bit adder, rippling each slice carry into the next slice.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// RUN   | one slice per cycle through the adder, idx selects the slice
// DONE  | result held on out_sum/out_cout until out_ready
module adder_word_sequencer #(
    parameter int WORDS = 4,
    parameter int W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_word_sequencer_if.slave bus
);
    localparam int DW = W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   sum_q, sum_d;
    logic            carry_q, carry_d;
    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_sum_q, out_sum_d;
    logic            out_cout_q, out_cout_d;
    logic            last;

    assign last = (idx_q == IDX_LAST);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q*W +: W] = bus.add_sum;
                carry_d             = bus.add_cout;
                if (last) begin
                    // Result registers load only here so they hold across the next transaction.
                    out_sum_d   = sum_d;
                    out_cout_d  = bus.add_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;

    // The adder is combinational, so the slice result is captured in the same cycle.
    assign bus.add_a   = (state_q == RUN) ? a_q[idx_q*W +: W] : '0;
    assign bus.add_b   = (state_q == RUN) ? b_q[idx_q*W +: W] : '0;
    assign bus.add_cin = (state_q == RUN) ? carry_q : 1'b0;
endmodule

// File: tb/tb_adder_word_sequencer.sv
// Bench for adder_word_sequencer: a WORDS=4 and a WORDS=1 instance, each with a
// behavioural 16-bit adder, checked against whole-word arithmetic.
module tb_adder_word_sequencer;
    logic clk;
    logic rst_n4, rst_n1;
    int   errors;
    int   checks;

    adder_word_sequencer_if #(.WORDS(4)) b4 ();
    adder_word_sequencer_if #(.WORDS(1)) b1 ();

    adder_word_sequencer #(.WORDS(4)) u4 (.clk(clk), .rst_n(rst_n4), .bus(b4));
    adder_word_sequencer #(.WORDS(1)) u1 (.clk(clk), .rst_n(rst_n1), .bus(b1));

    // Stand-ins for the 16-bit combinational prefix adder.
    assign {b4.add_cout, b4.add_sum} = 17'(b4.add_a) + 17'(b4.add_b) + 17'(b4.add_cin);
    assign {b1.add_cout, b1.add_sum} = 17'(b1.add_a) + 17'(b1.add_b) + 17'(b1.add_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [64:0] ref_add(input logic [63:0] a, input logic [63:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + 65'(c);
    endfunction

    // Drive one pair into the WORDS=4 instance; return edges from accept to out_valid
    // (-1 on timeout) and the add_cin value seen in each RUN cycle.
    task automatic send4(input logic [63:0] a, input logic [63:0] b, input logic c,
                         output int lat, output logic [15:0] cins);
        int n;
        n = 0;
        while (b4.in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        b4.in_a = a; b4.in_b = b; b4.in_cin = c; b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        b4.in_a = rnd64(); b4.in_b = rnd64(); b4.in_cin = 1'($urandom);
        lat = 0;
        cins = '0;
        while (lat < 50) begin
            if (lat < 16) cins[lat] = b4.add_cin;
            @(posedge clk); #1; lat++;
            if (b4.out_valid === 1'b1) break;
        end
        if (b4.out_valid !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        b4.in_valid = 0; b4.in_a = '0; b4.in_b = '0; b4.in_cin = 0; b4.out_ready = 0;
        b1.in_valid = 0; b1.in_a = '0; b1.in_b = '0; b1.in_cin = 0; b1.out_ready = 0;
        rst_n4 = 0; rst_n1 = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (b4.out_valid !== 0 || b4.out_sum !== 64'h0 || b4.out_cout !== 0) begin
            errors++; $display("FAIL reset_out4: valid=%b sum=%h cout=%b, need 0/0/0", b4.out_valid, b4.out_sum, b4.out_cout);
        end
        checks++;
        if (b4.in_ready !== 0 || b1.in_ready !== 0) begin
            errors++; $display("FAIL reset_in_ready: got %b/%b, need 0/0", b4.in_ready, b1.in_ready);
        end
        checks++;
        if (b4.add_a !== 16'h0 || b4.add_b !== 16'h0 || b4.add_cin !== 0) begin
            errors++; $display("FAIL reset_add_idle: a=%h b=%h cin=%b, need 0", b4.add_a, b4.add_b, b4.add_cin);
        end
        checks++;
        if (b1.out_valid !== 0 || b1.out_sum !== 16'h0 || b1.out_cout !== 0) begin
            errors++; $display("FAIL reset_out1: valid=%b sum=%h cout=%b, need 0/0/0", b1.out_valid, b1.out_sum, b1.out_cout);
        end
        rst_n4 = 1; rst_n1 = 1;
        #1;
        checks++;
        if (b4.in_ready !== 1 || b1.in_ready !== 1) begin
            errors++; $display("FAIL release_in_ready: got %b/%b, need 1/1", b4.in_ready, b1.in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        int lat;
        logic [15:0] cins;
        b4.out_ready = 1;
        send4(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, cins);
        checks++;
        if (lat !== 4) begin
            errors++; $display("FAIL ripple_latency: got %0d edges, need 4", lat);
        end
        checks++;
        if (b4.out_sum !== 64'h0 || b4.out_cout !== 1'b1) begin
            errors++; $display("FAIL ripple_result: sum=%h cout=%b, need 0/1", b4.out_sum, b4.out_cout);
        end
        checks++;
        if (cins[3:0] !== 4'b1110) begin
            errors++; $display("FAIL ripple_cin_seq: got %b (slice3..0), need 1110", cins[3:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (b4.out_valid !== 0 || b4.in_ready !== 1) begin
            errors++; $display("FAIL ripple_release: valid=%b in_ready=%b, need 0/1", b4.out_valid, b4.in_ready);
        end
    endtask

    task automatic test_carry_in();
        int lat;
        logic [15:0] cins;
        send4(64'h0, 64'h0, 1'b1, lat, cins);
        checks++;
        if (lat !== 4 || b4.out_sum !== 64'h1 || b4.out_cout !== 1'b0) begin
            errors++; $display("FAIL cin_only: lat=%0d sum=%h cout=%b, need 4/1/0", lat, b4.out_sum, b4.out_cout);
        end
        checks++;
        if (cins[3:0] !== 4'b0001) begin
            errors++; $display("FAIL cin_only_seq: got %b (slice3..0), need 0001", cins[3:0]);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mixed();
        int lat;
        logic [15:0] cins;
        send4(64'h1234_8000_FFFF_0001, 64'h0001_8000_0001_FFFF, 1'b0, lat, cins);
        checks++;
        if (lat !== 4 || b4.out_sum !== 64'h1236_0001_0001_0000 || b4.out_cout !== 1'b0) begin
            errors++; $display("FAIL mixed: lat=%0d sum=%h cout=%b, need 4/1236000100010000/0", lat, b4.out_sum, b4.out_cout);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, k;
        logic [15:0] cins;
        logic [63:0] a, b;
        logic c;
        logic [64:0] e;
        for (int i = 0; i < 3000; i++) begin
            a = rnd64();
            b = rnd64();
            if ($urandom_range(0, 7) == 0) a = ~b;
            c = 1'($urandom);
            e = ref_add(a, b, c);
            b4.out_ready = 0;
            send4(a, b, c, lat, cins);
            k = $urandom_range(0, 3);
            repeat (k) begin @(posedge clk); #1; end
            checks++;
            if (lat !== 4 || b4.out_valid !== 1 || {b4.out_cout, b4.out_sum} !== e) begin
                errors++;
                $display("FAIL random[%0d]: lat=%0d valid=%b got %h, need %h", i, lat, b4.out_valid, {b4.out_cout, b4.out_sum}, e);
            end
            b4.out_ready = 1;
            @(posedge clk); #1;
            b4.out_ready = 0;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] cins;
        logic [63:0] xa, xb;
        logic xc;
        logic [64:0] e1, e2;
        e1 = ref_add(64'hDEAD_BEEF_0123_4567, 64'h8000_0000_FFFF_FFFF, 1'b1);
        xa = rnd64(); xb = rnd64(); xc = 1'($urandom);
        e2 = ref_add(xa, xb, xc);
        b4.out_ready = 0;
        send4(64'hDEAD_BEEF_0123_4567, 64'h8000_0000_FFFF_FFFF, 1'b1, lat, cins);
        b4.in_a = xa; b4.in_b = xb; b4.in_cin = xc; b4.in_valid = 1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            checks++;
            if (b4.out_valid !== 1 || {b4.out_cout, b4.out_sum} !== e1 || b4.in_ready !== 0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b got %h need %h in_ready=%b", i, b4.out_valid, {b4.out_cout, b4.out_sum}, e1, b4.in_ready);
            end
        end
        b4.out_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (b4.out_valid !== 0 || b4.in_ready !== 1 || {b4.out_cout, b4.out_sum} !== e1) begin
            errors++;
            $display("FAIL bp_release: valid=%b in_ready=%b got %h, need 0/1/%h", b4.out_valid, b4.in_ready, {b4.out_cout, b4.out_sum}, e1);
        end
        @(posedge clk); #1;
        b4.in_valid = 0;
        checks++;
        if (b4.in_ready !== 0) begin
            errors++; $display("FAIL bp_accept: in_ready=%b after accept edge, need 0", b4.in_ready);
        end
        lat = 0;
        while (b4.out_valid !== 1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat !== 4 || {b4.out_cout, b4.out_sum} !== e2) begin
            errors++; $display("FAIL bp_second: lat=%0d got %h, need 4/%h", lat, {b4.out_cout, b4.out_sum}, e2);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [64:0] q[$];
        logic [64:0] e;
        logic acc;
        int last_acc, n_acc;
        b4.out_ready = 1;
        b4.in_a = rnd64(); b4.in_b = rnd64(); b4.in_cin = 1'($urandom);
        b4.in_valid = 1;
        last_acc = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 62; cyc++) begin
            acc = b4.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                q.push_back(ref_add(b4.in_a, b4.in_b, b4.in_cin));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 6) begin
                        errors++; $display("FAIL b2b_spacing: %0d cycles between accepts, need 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
                b4.in_a = rnd64(); b4.in_b = rnd64(); b4.in_cin = 1'($urandom);
            end
            if (b4.out_valid === 1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious: out_valid with nothing outstanding");
                end else begin
                    e = q.pop_front();
                    if ({b4.out_cout, b4.out_sum} !== e) begin
                        errors++; $display("FAIL b2b_result: got %h, need %h", {b4.out_cout, b4.out_sum}, e);
                    end
                end
            end
        end
        b4.in_valid = 0;
        checks++;
        if (n_acc < 10) begin
            errors++; $display("FAIL b2b_count: %0d accepts in 62 cycles, need 10", n_acc);
        end
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        int pulses;
        b4.out_ready = 1;
        b4.in_a = rnd64(); b4.in_b = rnd64(); b4.in_cin = 1'($urandom);
        b4.in_valid = 1;
        @(posedge clk); #1;
        b4.in_valid = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n4 = 0;
        @(posedge clk); #1;
        checks++;
        if (b4.out_valid !== 0 || b4.out_sum !== 64'h0 || b4.out_cout !== 0 || b4.in_ready !== 0) begin
            errors++;
            $display("FAIL midreset_state: valid=%b sum=%h cout=%b in_ready=%b, need 0/0/0/0", b4.out_valid, b4.out_sum, b4.out_cout, b4.in_ready);
        end
        checks++;
        if (b4.add_a !== 16'h0 || b4.add_cin !== 0) begin
            errors++; $display("FAIL midreset_add: add_a=%h add_cin=%b, need 0/0", b4.add_a, b4.add_cin);
        end
        rst_n4 = 1;
        #1;
        checks++;
        if (b4.in_ready !== 1) begin
            errors++; $display("FAIL midreset_ready: in_ready=%b after release, need 1", b4.in_ready);
        end
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (b4.out_valid === 1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++; $display("FAIL midreset_pulse: %0d out_valid cycles after abort, need 0", pulses);
        end
    endtask

    task automatic test_words1();
        logic [16:0] q[$];
        logic [16:0] e;
        logic acc;
        int last_acc, n_acc;
        b1.out_ready = 1;
        b1.in_a = 16'hFFFF; b1.in_b = 16'hFFFF; b1.in_cin = 1; b1.in_valid = 1;
        @(posedge clk); #1;
        b1.in_valid = 0;
        checks++;
        if (b1.add_cin !== 1 || b1.add_a !== 16'hFFFF || b1.out_valid !== 0) begin
            errors++; $display("FAIL w1_run: add_cin=%b add_a=%h valid=%b, need 1/ffff/0", b1.add_cin, b1.add_a, b1.out_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (b1.out_valid !== 1 || b1.out_sum !== 16'hFFFF || b1.out_cout !== 1) begin
            errors++; $display("FAIL w1_result: valid=%b sum=%h cout=%b, need 1/ffff/1", b1.out_valid, b1.out_sum, b1.out_cout);
        end
        @(posedge clk); #1;
        checks++;
        if (b1.out_valid !== 0 || b1.in_ready !== 1) begin
            errors++; $display("FAIL w1_release: valid=%b in_ready=%b, need 0/1", b1.out_valid, b1.in_ready);
        end
        b1.in_a = 16'($urandom); b1.in_b = 16'($urandom); b1.in_cin = 1'($urandom);
        b1.in_valid = 1;
        last_acc = -1;
        n_acc = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            acc = b1.in_ready;
            @(posedge clk); #1;
            if (acc) begin
                q.push_back(17'(b1.in_a) + 17'(b1.in_b) + 17'(b1.in_cin));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        errors++; $display("FAIL w1_spacing: %0d cycles between accepts, need 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                n_acc++;
                b1.in_a = 16'($urandom); b1.in_b = 16'($urandom); b1.in_cin = 1'($urandom);
            end
            if (b1.out_valid === 1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL w1_spurious: out_valid with nothing outstanding");
                end else begin
                    e = q.pop_front();
                    if ({b1.out_cout, b1.out_sum} !== e) begin
                        errors++; $display("FAIL w1_b2b_result: got %h, need %h", {b1.out_cout, b1.out_sum}, e);
                    end
                end
            end
        end
        b1.in_valid = 0;
        checks++;
        if (n_acc < 13) begin
            errors++; $display("FAIL w1_count: %0d accepts in 40 cycles, need 13", n_acc);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_carry_ripple();
        test_carry_in();
        test_mixed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_words1();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
